i2c_target: RTL and testbench

Single-address I2C target (slave) that answers the master-side I2C blocks in the same codebase on a shared SCL/SDA bus. It oversamples SCL and SDA on the system clock, detects START and STOP, matches a 7-bit address and acknowledges it. Write bytes are delivered as parallel data with a valid strobe. Read bytes are fetched from the user through a request/sample handshake. The target never stretches SCL and only ever pulls SDA low.

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_bus_sync.sv | 77 +++++++
 rtl/i2c_target.sv | 265 ++++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : i2c_pkg                                                   |
// | Purpose  : Shared I2C definitions: target FSM state encoding and     |
// |            the ACK/NACK and read/write bit values as seen on SDA.    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package i2c_pkg;

    // Target FSM state encoding
    typedef logic [2:0] state_t;

    localparam state_t c_st_idle     = 3'd0;
    localparam state_t c_st_addr     = 3'd1;
    localparam state_t c_st_addr_ack = 3'd2;
    localparam state_t c_st_rx_byte  = 3'd3;
    localparam state_t c_st_rx_ack   = 3'd4;
    localparam state_t c_st_tx_byte  = 3'd5;
    localparam state_t c_st_tx_ack   = 3'd6;
    localparam state_t c_st_ignore   = 3'd7;

    // Bus-level bit meanings
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic I2C_WR   = 1'b0;
    localparam logic I2C_RD   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : i2c_bus_sync                                              |
// | Purpose  : Brings SCL/SDA into the clk domain and produces one-clk   |
// |            SCL rise/fall and START/STOP pulses.                      |
// | Ports    : clk, rst (async, active-low)                              |
// |            i_scl, i_sda     raw bus pins                             |
// |            o_sda            SDA value belonging to the pulse cycle   |
// |            o_scl_rise/fall  registered SCL edge pulses               |
// |            o_start/o_stop   registered bus condition pulses          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    // Never fewer than two synchronizer flops, whatever is requested
    localparam int c_STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [c_STAGES-1:0] r_scl_sync;
    logic [c_STAGES-1:0] r_sda_sync;
    logic                r_scl_d;
    logic                r_sda_d;
    logic                r_scl_rise;
    logic                r_scl_fall;
    logic                r_start;
    logic                r_stop;

    logic w_scl;
    logic w_sda;

    assign w_scl = r_scl_sync[c_STAGES-1];
    assign w_sda = r_sda_sync[c_STAGES-1];

    // Bus idles high, so everything resets to 1 to avoid phantom edges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_scl_sync <= {r_scl_sync[c_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[c_STAGES-2:0], i_sda};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
            r_scl_rise <= w_scl & ~r_scl_d;
            r_scl_fall <= ~w_scl & r_scl_d;
            r_start    <= w_scl & r_scl_d & r_sda_d & ~w_sda;
            r_stop     <= w_scl & r_scl_d & ~r_sda_d & w_sda;
        end
    end

    // Pulses are registered one clk after detection; r_sda_d holds the
    // SDA value from the detection cycle, so it lines up with them.
    assign o_sda      = r_sda_d;
    assign o_scl_rise = r_scl_rise;
    assign o_scl_fall = r_scl_fall;
    assign o_start    = r_start;
    assign o_stop     = r_stop;

endmodule
`default_nettype wire

// File: rtl/i2c_target.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : i2c_target                                                |
// | Purpose  : Single-address I2C target. Oversamples SCL/SDA, ACKs its  |
// |            address, delivers write bytes and fetches read bytes      |
// |            through a request handshake. Never stretches SCL.         |
// | Ports    : clk, rst (async, active-low), enable (low = held idle)    |
// |            SCL, SDA      bus inputs                                  |
// |            sda_pull      1 = pull SDA low                            |
// |            addressed     high from address ACK until STOP/rSTART     |
// |            rx_data/rx_valid  received write byte + one-clk strobe    |
// |            tx_data/tx_req    read byte + one-clk request pulse       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module i2c_target #(
    parameter logic [6:0] ADDR        = 7'h3C,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       SCL,
    input  logic       SDA,
    output logic       sda_pull,
    output logic       addressed,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req
);

    import i2c_pkg::*;

    logic w_sda;
    logic w_rise;
    logic w_fall;
    logic w_start;
    logic w_stop;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk        (clk),
        .rst        (rst),
        .i_scl      (SCL),
        .i_sda      (SDA),
        .o_sda      (w_sda),
        .o_scl_rise (w_rise),
        .o_scl_fall (w_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    state_t     r_state;
    logic [7:0] r_shift;
    logic [3:0] r_cnt;
    logic       r_rw;
    logic       r_sda_pull;
    logic       r_addressed;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_tx_req;

    state_t     w_state_next;
    logic [7:0] w_shift_next;
    logic [3:0] w_cnt_next;
    logic       w_rw_next;
    logic       w_sda_pull_next;
    logic       w_addressed_next;
    logic [7:0] w_rx_data_next;
    logic       w_rx_valid_next;
    logic       w_tx_req_next;

    logic [7:0] w_byte_in;
    logic       w_last_bit;
    logic       w_addr_hit;

    assign w_byte_in  = {r_shift[6:0], w_sda};
    assign w_last_bit = (r_cnt == 4'd7);
    assign w_addr_hit = (w_byte_in[7:1] == ADDR);

    // ------------------------------------------------------------------
    // State and datapath registers. enable low behaves like reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_st_idle;
            r_shift     <= 8'h00;
            r_cnt       <= 4'd0;
            r_rw        <= I2C_WR;
            r_sda_pull  <= 1'b0;
            r_addressed <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_tx_req    <= 1'b0;
        end else if (!enable) begin
            r_state     <= c_st_idle;
            r_shift     <= 8'h00;
            r_cnt       <= 4'd0;
            r_rw        <= I2C_WR;
            r_sda_pull  <= 1'b0;
            r_addressed <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_tx_req    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_shift     <= w_shift_next;
            r_cnt       <= w_cnt_next;
            r_rw        <= w_rw_next;
            r_sda_pull  <= w_sda_pull_next;
            r_addressed <= w_addressed_next;
            r_rx_data   <= w_rx_data_next;
            r_rx_valid  <= w_rx_valid_next;
            r_tx_req    <= w_tx_req_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. START/STOP override any bit activity.
    // In the two ACK states the current sda_pull tells whether the ACK
    // slot has begun (first fall drives it, second fall ends it).
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (w_stop) begin
            w_state_next = c_st_idle;
        end else if (w_start) begin
            w_state_next = c_st_addr;
        end else begin
            case (r_state)
                c_st_addr: begin
                    if (w_rise && w_last_bit)
                        w_state_next = w_addr_hit ? c_st_addr_ack : c_st_ignore;
                end
                c_st_addr_ack: begin
                    if (w_fall && r_sda_pull)
                        w_state_next = (r_rw == I2C_RD) ? c_st_tx_byte : c_st_rx_byte;
                end
                c_st_rx_byte: begin
                    if (w_rise && w_last_bit)
                        w_state_next = c_st_rx_ack;
                end
                c_st_rx_ack: begin
                    if (w_fall && r_sda_pull)
                        w_state_next = c_st_rx_byte;
                end
                c_st_tx_byte: begin
                    if (w_fall && (r_cnt == 4'd8))
                        w_state_next = c_st_tx_ack;
                end
                c_st_tx_ack: begin
                    if (w_rise && (w_sda == I2C_NACK))
                        w_state_next = c_st_ignore;
                    else if (w_fall && (r_cnt != 4'd0))
                        w_state_next = c_st_tx_byte;
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_shift_next     = r_shift;
        w_cnt_next       = r_cnt;
        w_rw_next        = r_rw;
        w_sda_pull_next  = r_sda_pull;
        w_addressed_next = r_addressed;
        w_rx_data_next   = r_rx_data;
        w_rx_valid_next  = 1'b0;
        w_tx_req_next    = 1'b0;

        if (w_stop || w_start) begin
            w_cnt_next       = 4'd0;
            w_sda_pull_next  = 1'b0;
            w_addressed_next = 1'b0;
        end else begin
            case (r_state)
                c_st_addr: begin
                    if (w_rise) begin
                        w_shift_next = w_byte_in;
                        w_cnt_next   = r_cnt + 4'd1;
                        if (w_last_bit) begin
                            w_cnt_next = 4'd0;
                            if (w_addr_hit)
                                w_rw_next = w_byte_in[0];
                        end
                    end
                end
                c_st_addr_ack: begin
                    if (w_rise && r_sda_pull && (r_rw == I2C_RD))
                        w_tx_req_next = 1'b1;
                    if (w_fall) begin
                        if (!r_sda_pull) begin
                            w_sda_pull_next  = 1'b1;
                            w_addressed_next = 1'b1;
                        end else if (r_rw == I2C_RD) begin
                            w_shift_next    = tx_data;
                            w_sda_pull_next = ~tx_data[7];
                            w_cnt_next      = 4'd0;
                        end else begin
                            w_sda_pull_next = 1'b0;
                            w_cnt_next      = 4'd0;
                        end
                    end
                end
                c_st_rx_byte: begin
                    if (w_rise) begin
                        w_shift_next = w_byte_in;
                        w_cnt_next   = r_cnt + 4'd1;
                        if (w_last_bit) begin
                            w_rx_data_next  = w_byte_in;
                            w_rx_valid_next = 1'b1;
                            w_cnt_next      = 4'd0;
                        end
                    end
                end
                c_st_rx_ack: begin
                    if (w_fall)
                        w_sda_pull_next = ~r_sda_pull;
                end
                c_st_tx_byte: begin
                    // Count rises; after the 8th bit's fall hand SDA back
                    if (w_rise)
                        w_cnt_next = r_cnt + 4'd1;
                    if (w_fall) begin
                        if (r_cnt == 4'd8) begin
                            w_sda_pull_next = 1'b0;
                            w_cnt_next      = 4'd0;
                        end else begin
                            w_shift_next    = {r_shift[6:0], 1'b0};
                            w_sda_pull_next = ~r_shift[6];
                        end
                    end
                end
                c_st_tx_ack: begin
                    // r_cnt != 0 marks "master ACKed, load on next fall"
                    if (w_rise && (w_sda == I2C_ACK)) begin
                        w_tx_req_next = 1'b1;
                        w_cnt_next    = 4'd1;
                    end
                    if (w_fall && (r_cnt != 4'd0)) begin
                        w_shift_next    = tx_data;
                        w_sda_pull_next = ~tx_data[7];
                        w_cnt_next      = 4'd0;
                    end
                end
                default: begin
                    w_sda_pull_next = 1'b0;
                end
            endcase
        end
    end

    assign sda_pull  = r_sda_pull;
    assign addressed = r_addressed;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign tx_req    = r_tx_req;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_i2c_target                                             |
// | Purpose  : Self-checking bench for i2c_target: a bus master model    |
// |            drives transfers; expectations come from a transaction-   |
// |            level model of the target (address match, ACK, data).    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_i2c_target;

    localparam int         c_Q      = 100;    // quarter SCL period
    localparam logic [6:0] c_TARGET = 7'h3C;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       m_scl;
    logic       m_sda;
    logic       w_sda_line;
    logic       sda_pull;
    logic       addressed;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0] rx_log[$];
    logic [7:0] tx_q[$];
    logic [7:0] wbuf[$];
    logic [7:0] rbuf[$];
    int         tx_req_cnt = 0;
    int         tx_idx     = 0;
    bit         seen_pull  = 0;
    bit         seen_addr  = 0;

    // Open-drain wired AND of master and target
    assign w_sda_line = m_sda & ~sda_pull;

    i2c_target #(
        .ADDR        (7'h3C),
        .SYNC_STAGES (2)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .SCL       (m_scl),
        .SDA       (w_sda_line),
        .sda_pull  (sda_pull),
        .addressed (addressed),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_req    (tx_req)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // User side: log write bytes, answer read requests, note bus activity
    initial begin
        forever begin
            @(negedge clk);
            if (rx_valid === 1'b1) rx_log.push_back(rx_data);
            if (tx_req === 1'b1) begin
                tx_req_cnt++;
                if (tx_idx < tx_q.size()) tx_data = tx_q[tx_idx];
                tx_idx++;
            end
            if (sda_pull === 1'b1)  seen_pull = 1'b1;
            if (addressed === 1'b1) seen_addr = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: the target answers only its own 7-bit address
    function automatic bit model_hit(input logic [7:0] addr_byte);
        return (addr_byte[7:1] == c_TARGET);
    endfunction

    // ---------------- bus master primitives ----------------
    task automatic bus_start();
        m_sda = 1'b1; #(c_Q);
        m_scl = 1'b1; #(c_Q);
        m_sda = 1'b0; #(c_Q);
        m_scl = 1'b0; #(c_Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; #(c_Q);
        m_scl = 1'b1; #(c_Q);
        m_sda = 1'b1; #(2*c_Q);
    endtask

    task automatic clock_bit(input logic b, output logic r);
        m_sda = b;    #(c_Q);
        m_scl = 1'b1; #(c_Q);
        r = w_sda_line; #(c_Q);
        m_scl = 1'b0; #(c_Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], dummy);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        logic dummy;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, b);
            d = {d[6:0], b};
        end
        clock_bit(nack, dummy);
    endtask

    // ---------------- transaction-level scenarios ----------------
    task automatic run_write(input string tag, input logic [7:0] ab);
        logic       ack;
        logic [7:0] exp_rx[$];
        bit         hit;
        hit = model_hit(ab);
        rx_log.delete();
        seen_pull = 1'b0;
        seen_addr = 1'b0;
        bus_start();
        write_byte(ab, ack);
        check({tag, "_addr_ack"}, 32'(ack), 32'(hit ? 1'b0 : 1'b1));
        foreach (wbuf[i]) begin
            write_byte(wbuf[i], ack);
            check({tag, "_data_ack"}, 32'(ack), 32'(hit ? 1'b0 : 1'b1));
            if (hit) exp_rx.push_back(wbuf[i]);
        end
        check({tag, "_addressed"}, 32'(addressed), 32'(hit));
        bus_stop();
        check({tag, "_addressed_after_stop"}, 32'(addressed), 32'd0);
        check({tag, "_rx_count"}, 32'(rx_log.size()), 32'(exp_rx.size()));
        foreach (exp_rx[i])
            if (i < rx_log.size()) check({tag, "_rx_byte"}, 32'(rx_log[i]), 32'(exp_rx[i]));
        check({tag, "_seen_addressed"}, 32'(seen_addr), 32'(hit));
        if (!hit) check({tag, "_never_pulled"}, 32'(seen_pull), 32'd0);
    endtask

    task automatic run_read(input string tag);
        logic       ack;
        logic [7:0] d;
        tx_q       = rbuf;
        tx_idx     = 0;
        tx_req_cnt = 0;
        bus_start();
        write_byte(8'h79, ack);
        check({tag, "_addr_ack"}, 32'(ack), 32'd0);
        foreach (rbuf[i]) begin
            read_byte(d, (i == rbuf.size() - 1) ? 1'b1 : 1'b0);
            check({tag, "_rd_byte"}, 32'(d), 32'(rbuf[i]));
        end
        check({tag, "_released_after_nack"}, 32'(sda_pull), 32'd0);
        check({tag, "_tx_req_count"}, 32'(tx_req_cnt), 32'(rbuf.size()));
        bus_stop();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic       ack;
        logic       dummy;
        logic [7:0] d;
        logic [7:0] ab;

        rst     = 1'b0;
        enable  = 1'b1;
        m_scl   = 1'b1;
        m_sda   = 1'b1;
        tx_data = 8'h00;
        #41;
        check("reset_sda_pull",  32'(sda_pull),  32'd0);
        check("reset_addressed", 32'(addressed), 32'd0);
        check("reset_rx_data",   32'(rx_data),   32'd0);
        check("reset_rx_valid",  32'(rx_valid),  32'd0);
        check("reset_tx_req",    32'(tx_req),    32'd0);
        #9;
        rst = 1'b1;
        #(c_Q);

        // Basic write
        wbuf = '{8'hA5, 8'h5A};
        run_write("wr", 8'h78);

        // Address mismatch
        wbuf = '{8'h11};
        run_write("mismatch", 8'h7A);

        // Basic read: ACK after first byte, NACK after second
        rbuf = '{8'hC3, 8'h3C};
        run_read("rd");

        // Repeated START four bits into a write byte, then a read
        rx_log.delete();
        rbuf       = '{8'h96};
        tx_q       = rbuf;
        tx_idx     = 0;
        tx_req_cnt = 0;
        bus_start();
        write_byte(8'h78, ack);
        check("rs_wr_addr_ack", 32'(ack), 32'd0);
        clock_bit(1'b1, dummy);
        clock_bit(1'b0, dummy);
        clock_bit(1'b1, dummy);
        clock_bit(1'b1, dummy);
        bus_start();
        write_byte(8'h79, ack);
        check("rs_rd_addr_ack", 32'(ack), 32'd0);
        read_byte(d, 1'b1);
        check("rs_rd_byte", 32'(d), 32'h96);
        check("rs_no_rx_valid", 32'(rx_log.size()), 32'd0);
        check("rs_tx_req_count", 32'(tx_req_cnt), 32'd1);
        bus_stop();

        // Reset while the address ACK is being driven
        bus_start();
        for (int i = 7; i >= 0; i--) clock_bit(((8'h78 >> i) & 8'h01) != 8'h00, dummy);
        m_sda = 1'b1;
        check("rst_pull_before", 32'(sda_pull), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_async_release", 32'(sda_pull), 32'd0);
        #(c_Q);
        m_scl = 1'b1;
        #(c_Q);
        rst = 1'b1;
        #(c_Q);
        wbuf = '{8'h42};
        run_write("rst_recover", 8'h78);

        // enable dropped for one clk in the middle of a data byte
        rx_log.delete();
        bus_start();
        write_byte(8'h78, ack);
        check("en_addr_ack", 32'(ack), 32'd0);
        clock_bit(1'b1, dummy);
        clock_bit(1'b0, dummy);
        clock_bit(1'b1, dummy);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        #1;
        check("en_sda_released", 32'(sda_pull), 32'd0);
        check("en_not_addressed", 32'(addressed), 32'd0);
        for (int i = 0; i < 5; i++) clock_bit(1'b0, dummy);
        clock_bit(1'b1, ack);
        check("en_byte_not_acked", 32'(ack), 32'd1);
        write_byte(8'h00, ack);
        check("en_next_not_acked", 32'(ack), 32'd1);
        check("en_no_rx_valid", 32'(rx_log.size()), 32'd0);
        bus_stop();
        wbuf = '{8'h24};
        run_write("en_recover", 8'h78);

        // Randomized writes (some to foreign addresses) and reads
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 2) == 0) ab = {7'($urandom_range(0, 127)), 1'b0};
            else                           ab = 8'h78;
            wbuf.delete();
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) wbuf.push_back(8'($urandom));
            run_write("rnd_wr", ab);
        end
        for (int k = 0; k < 3; k++) begin
            rbuf.delete();
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) rbuf.push_back(8'($urandom));
            run_read("rnd_rd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
